// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Single-outstanding load/store unit between a CPU request port and a
//   byte-addressed, combinational-read data memory. Loads return a byte,
//   half or word that is sign- or zero-extended. Word stores write the
//   memory directly. Byte and half stores do a read-modify-write: the
//   memory word is read, the low lanes are replaced, and the word is
//   written back.
//
// Handshake:
//   A request transfers on a rising edge where req_valid=1 and req_ready=1.
//   req_ready is high only while idle, so at most one access is in flight.
//   The response is a one-cycle resp_valid strobe with no backpressure.
//   resp_err and resp_rdata are meaningful only while resp_valid=1, and
//   both read 0 at all other times.
//
// Ports:
//   clk, rstn        clock and synchronous active-low reset
//   req_*            CPU request (valid/ready, write, size, unsigned, addr, wdata)
//   resp_*           response strobe, extended load data, error flag
//   mem_*            data memory address, write word, write strobe, read
//                    qualifier and combinational read word
//   dbg_state        current FSM state, for observation only
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [1:0]  SZ_RSVD = 2'b11;
    localparam logic [32:0] LIMIT   = 33'(MEM_BYTES);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_captured;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_err;
    logic [32:0] w_end_addr;
    logic [31:0] w_merge;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign w_end_addr = {1'b0, req_addr} + 33'd4;
    assign w_err      = (req_size == SZ_RSVD) || (w_end_addr > LIMIT);

    // Read-modify-write merge: new data replaces the low lanes of the word
    // currently presented by the memory.
    always_comb begin
        w_merge = r_wdata;
        case (r_size)
            SZ_BYTE: w_merge = {mem_read_data[31:8],  r_wdata[7:0]};
            SZ_HALF: w_merge = {mem_read_data[31:16], r_wdata[15:0]};
            default: w_merge = r_wdata;
        endcase
    end

    // State register plus latched request and memory-facing registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
            r_captured  <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
                r_err      <= w_err;
                // Rejected accesses leave the memory address/data untouched
                // so the memory port keeps its last values.
                if (!w_err) begin
                    r_mem_addr <= req_addr;
                    if (req_write && (req_size == SZ_WORD)) begin
                        r_mem_wdata <= req_wdata;
                    end
                end
            end
            if (r_state == ST_READ) begin
                r_captured <= mem_read_data;
                if (r_write) begin
                    r_mem_wdata <= w_merge;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_next_state = ST_RESP;
                    end else if (!req_write) begin
                        w_next_state = ST_READ;
                    end else if (req_size == SZ_WORD) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_READ:  w_next_state = r_write ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: functions of registered state only.
    always_comb begin
        req_ready    = (r_state == ST_IDLE);
        resp_valid   = (r_state == ST_RESP);
        resp_err     = (r_state == ST_RESP) && r_err;
        mem_memread  = (r_state == ST_READ);
        mem_memwrite = (r_state == ST_WRITE);
        resp_rdata   = 32'd0;
        if ((r_state == ST_RESP) && !r_err && !r_write) begin
            case (r_size)
                SZ_BYTE: resp_rdata = r_unsigned ? {24'd0, r_captured[7:0]}
                                                 : {{24{r_captured[7]}}, r_captured[7:0]};
                SZ_HALF: resp_rdata = r_unsigned ? {16'd0, r_captured[15:0]}
                                                 : {{16{r_captured[15]}}, r_captured[15:0]};
                default: resp_rdata = r_captured;
            endcase
        end
    end

    assign mem_address    = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Bench for load_store_unit with MEM_BYTES=128. A 128-byte memory model
// answers the DUT's memory port; a separate byte-array reference holds the
// memory contents the CPU should see, updated by plain byte-lane rules.
// Directed scenarios are followed by a randomized mix of accesses.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_read_data;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(128)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data),
        .dbg_state      (dbg_state)
    );

    // ---------------- memory model (single writer process) ----------------
    logic [7:0] mem [0:127];
    logic       bd_we = 1'b0;
    logic [6:0] bd_addr = 7'd0;
    logic [7:0] bd_data = 8'd0;

    always @(posedge clk) begin
        if (mem_memwrite) begin
            for (int i = 0; i < 4; i++) begin
                mem[7'(mem_address[6:0] + 7'(i))] <= mem_write_data[8*i +: 8];
            end
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    assign mem_read_data = {mem[mem_address[6:0] + 7'd3], mem[mem_address[6:0] + 7'd2],
                            mem[mem_address[6:0] + 7'd1], mem[mem_address[6:0]]};

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:127];

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[(a + 3) % 128], ref_mem[(a + 2) % 128],
                ref_mem[(a + 1) % 128], ref_mem[a % 128]};
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        return {mem[(a + 3) % 128], mem[(a + 2) % 128], mem[(a + 1) % 128], mem[a % 128]};
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] addr);
        longint unsigned end_addr;
        end_addr = longint'(addr) + 4;
        return (sz == 2'b11) || (end_addr > 128);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input int a);
        logic [31:0] w;
        int          nb;
        logic        sgn;
        w  = ref_word(a);
        nb = nbytes(sz);
        if (nb == 4) return w;
        sgn = w[8*nb - 1] && !uns;
        for (int i = nb; i < 4; i++) w[8*i +: 8] = sgn ? 8'hFF : 8'h00;
        return w;
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bd_write(input int a, input logic [7:0] d);
        bd_addr = 7'(a);
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic bd_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bd_write(a + i, w[8*i +: 8]);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic apply_reset();
        rstn      = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},    32'(req_ready),    32'd1);
        check_eq({tag, "_rvalid"},   32'(resp_valid),   32'd0);
        check_eq({tag, "_rerr"},     32'(resp_err),     32'd0);
        check_eq({tag, "_rdata"},    resp_rdata,        32'd0);
        check_eq({tag, "_memwrite"}, 32'(mem_memwrite), 32'd0);
        check_eq({tag, "_memread"},  32'(mem_memread),  32'd0);
        check_eq({tag, "_maddr"},    mem_address,       32'd0);
        check_eq({tag, "_mwdata"},   mem_write_data,    32'd0);
    endtask

    // One complete access with latency, strobe, data and memory checks.
    task automatic do_txn(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit          err;
        int          exp_lat, exp_reads, exp_writes, nb, a;
        int          k, nr, nw, both;
        logic [31:0] exp_rdata, exp_wword, wtmp;

        err = ref_err(sz, addr);
        a   = int'(addr[6:0]);
        nb  = nbytes(sz);
        exp_rdata = 32'd0;
        exp_wword = 32'd0;
        if (err) begin
            exp_lat = 1; exp_reads = 0; exp_writes = 0;
        end else if (!wr) begin
            exp_lat = 2; exp_reads = 1; exp_writes = 0;
            exp_rdata = ref_load(sz, uns, a);
        end else begin
            exp_writes = 1;
            exp_reads  = (nb == 4) ? 0 : 1;
            exp_lat    = (nb == 4) ? 2 : 3;
            wtmp = ref_word(a);
            for (int i = 0; i < nb; i++) wtmp[8*i +: 8] = wd[8*i +: 8];
            exp_wword = wtmp;
        end

        wait_ready();
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 1; nr = 0; nw = 0; both = 0;
        while (!resp_valid && k < 10) begin
            if (mem_memread) begin
                nr++;
                check_eq("read_addr", mem_address, addr);
            end
            if (mem_memwrite) begin
                nw++;
                check_eq("write_addr", mem_address, addr);
                check_eq("write_data", mem_write_data, exp_wword);
            end
            if (mem_memread && mem_memwrite) both++;
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("resp_seen",    32'(resp_valid), 32'd1);
        check_eq("latency",      32'(k),          32'(exp_lat));
        check_eq("resp_err",     32'(resp_err),   32'(err));
        check_eq("resp_rdata",   resp_rdata,      exp_rdata);
        check_eq("n_reads",      32'(nr),         32'(exp_reads));
        check_eq("n_writes",     32'(nw),         32'(exp_writes));
        check_eq("both_strobes", 32'(both),       32'd0);
        check_eq("resp_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);

        if (wr && !err) begin
            for (int i = 0; i < nb; i++) ref_mem[(a + i) % 128] = wd[8*i +: 8];
            check_eq("mem_word", mem_word(a), ref_word(a));
        end
        @(posedge clk);
        #1;
        check_eq("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] old_word, exp1, exp2;
        int          bad;

        apply_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 128; i++) bd_write(i, 8'($urandom));

        // Word store then load.
        do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check_eq("deadbeef_mem", mem_word(16), 32'hDEADBEEF);
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);

        // Byte store read-modify-write.
        bd_word(32'h20, 32'h11223344);
        do_txn(1'b1, 2'b00, 1'b0, 32'h20, 32'h000000AA);
        check_eq("rmw_mem", mem_word(32), 32'h112233AA);
        do_txn(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF);

        // Sign and zero extension.
        bd_word(32'h30, 32'h0000F080);
        do_txn(1'b0, 2'b00, 1'b0, 32'h30, 32'd0);
        do_txn(1'b0, 2'b00, 1'b1, 32'h30, 32'd0);
        do_txn(1'b0, 2'b01, 1'b0, 32'h30, 32'd0);
        do_txn(1'b0, 2'b01, 1'b1, 32'h30, 32'd0);

        // Range and reserved-size errors.
        do_txn(1'b0, 2'b10, 1'b0, 32'h7C, 32'd0);
        do_txn(1'b0, 2'b00, 1'b0, 32'h7D, 32'd0);
        do_txn(1'b1, 2'b10, 1'b0, 32'h7D, 32'h12345678);
        do_txn(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'd0);
        do_txn(1'b1, 2'b00, 1'b0, 32'hFFFFFFFE, 32'h55);
        do_txn(1'b0, 2'b11, 1'b0, 32'h04, 32'd0);

        // Reset during the READ cycle of a byte store.
        bd_word(32'h40, 32'hCAFEF00D);
        old_word = ref_word(64);
        wait_ready();
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_in_read", 32'(mem_memread), 32'd1);
        rstn = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_reset_outputs("abort");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_memwrite || resp_valid) bad++;
            @(posedge clk);
            #1;
        end
        check_eq("abort_quiet", 32'(bad), 32'd0);
        check_eq("abort_mem", mem_word(64), old_word);

        // Back-to-back loads with req_valid held high.
        exp1 = ref_load(2'b10, 1'b0, 16);
        exp2 = ref_load(2'b00, 1'b0, 48);
        wait_ready();
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_size = 2'b00; req_addr = 32'h30;
        check_eq("b2b_read1_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("b2b_resp1_ready", 32'(req_ready), 32'd0);
        check_eq("b2b_resp1_valid", 32'(resp_valid), 32'd1);
        check_eq("b2b_resp1_data", resp_rdata, exp1);
        @(posedge clk);
        #1;
        check_eq("b2b_idle_ready", 32'(req_ready), 32'd1);
        check_eq("b2b_idle_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("b2b_read2_ready", 32'(req_ready), 32'd0);
        check_eq("b2b_read2_rd", 32'(mem_memread), 32'd1);
        check_eq("b2b_read2_addr", mem_address, 32'h30);
        @(posedge clk);
        #1;
        check_eq("b2b_resp2_ready", 32'(req_ready), 32'd0);
        check_eq("b2b_resp2_valid", 32'(resp_valid), 32'd1);
        check_eq("b2b_resp2_data", resp_rdata, exp2);
        @(posedge clk);
        #1;
        check_eq("b2b_end_ready", 32'(req_ready), 32'd1);

        // Randomized mix.
        for (int t = 0; t < 250; t++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 127)) : $urandom;
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
        end

        // Whole-memory comparison against the reference.
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_eq("final_mem", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter, MEM_BYTES, default 128, giving the data memory size in bytes.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  Reset, synchronous and active-low.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  Block can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 req_unsigned  input  1  Loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  Byte address.
REQ-010 req_wdata  input  32  Store data, right-aligned.
REQ-011 resp_valid  output  1  One-cycle response strobe.
REQ-012 resp_rdata  output  32  Load result, extended.
REQ-013 resp_err  output  1  Access rejected; valid with resp_valid.
REQ-014 mem_address  output  32  Byte address to data memory.
REQ-015 mem_write_data  output  32  Word written to data memory.
REQ-016 mem_memwrite  output  1  Write strobe, committed at the clock edge.
REQ-017 mem_memread  output  1  Read qualifier.
REQ-018 mem_read_data  input  32  Combinational read word; byte at mem_address is on bits [7:0] (little-endian).

Function
REQ-019 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, and all request fields are latched at that edge.
REQ-021 The error condition SHALL be req_size=11, or {1'b0,req_addr}+4 > MEM_BYTES, computed at 33 bits so no wrap-around occurs.
REQ-022 FSM transitions from IDLE on acceptance:
- error -> RESP with resp_err=1 and no memory strobe;
- load -> READ;
- word store -> WRITE;
- byte or half store -> READ.
REQ-023 READ SHALL drive mem_memread=1 with mem_address equal to the latched address, and capture mem_read_data at the end of the cycle.
- Next state: RESP for a load; WRITE for a store.
REQ-024 WRITE SHALL drive mem_memwrite=1 for exactly one cycle with mem_address equal to the latched address, then go to RESP.
- mem_write_data for a word store: req_wdata.
- Byte store: {captured[31:8], wdata[7:0]}.
- Half store: {captured[31:16], wdata[15:0]}.
REQ-025 RESP SHALL assert resp_valid=1 for one cycle and then return to IDLE; there is no response backpressure.
REQ-026 resp_rdata for a load SHALL be:
- byte: captured[7:0] extended per req_unsigned;
- half: captured[15:0] extended per req_unsigned;
- word: captured[31:0].
- It SHALL be 0 for stores and errors.
REQ-027 Latency, from the acceptance edge to the cycle with resp_valid=1, SHALL be:
- load: 2 cycles;
- word store: 2 cycles;
- byte or half store: 3 cycles;
- error: 1 cycle.
REQ-028 mem_* outputs SHALL depend only on registered state, with no combinational path from req_* to mem_*.
REQ-029 Outside READ and WRITE, mem_memread and mem_memwrite SHALL be 0.
REQ-030 Outside READ and WRITE, mem_address and mem_write_data SHALL hold their last values.
REQ-031 The block SHALL never assert mem_memread and mem_memwrite in the same cycle.
REQ-032 req_valid held high in IDLE directly after RESP SHALL be accepted on the IDLE-cycle edge, giving at most one request in flight.

Reset
REQ-033 While rstn=0 at a rising edge, the state SHALL become IDLE.
REQ-034 After that reset edge, the outputs SHALL be:
- req_ready=1;
- resp_valid=0, resp_err=0, resp_rdata=0;
- mem_memwrite=0, mem_memread=0;
- mem_address=0, mem_write_data=0;
- all captured and latched registers 0.
REQ-035 Reset asserted in any state, including mid-read-modify-write, SHALL abort the access: no memwrite strobe issues after the reset edge, and no response is produced for the aborted request.

Verification
REQ-036 Word store then load: store addr=0x10, wdata=0xDEADBEEF.
- Response: memwrite at 0x10 with data 0xDEADBEEF; resp_valid 2 cycles after acceptance.
- Load word at 0x10: resp_rdata=0xDEADBEEF.
REQ-037 Byte store read-modify-write: memory word at 0x20 is 0x11223344; byte store of 0xAA at 0x20.
- Response: READ cycle, then WRITE cycle with data 0x112233AA; resp_valid 3 cycles after acceptance.
REQ-038 Sign and zero extension: memory at 0x30 holds 0x0000F080.
- Signed byte load: 0xFFFFFF80.
- Unsigned byte load: 0x00000080.
- Signed half load: 0xFFFFF080.
REQ-039 Range and reserved-size errors, MEM_BYTES=128:
- Word load at 0x7C: no error.
- Access at 0x7D: resp_err=1 one cycle after acceptance, no memread or memwrite.
- Access at 0xFFFFFFFE: resp_err=1, no wrap.
- req_size=11: resp_err=1.
REQ-040 Reset mid-operation: assert rstn=0 in the WRITE-pending cycle (READ state) of a byte store.
- Required response: no memwrite, the memory word is unchanged, req_ready=1 after reset, and no resp_valid.
REQ-041 Back-to-back requests: req_valid held high for two loads.
- Required response: the second load is accepted on the IDLE cycle after the first RESP, and req_ready=0 in all other states.
